// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin arbiter that shares one sequential 32/16
// divider among NREQ requesters and returns tagged results on a single
// response channel with backpressure. Divide-by-zero is answered directly
// without starting the divider.
module div_share_ctrl #(
   parameter int NREQ       = 4,
   parameter int IDW        = 2,
   parameter int DIV_CYCLES = 33
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*32-1:0]   req_a,
   input  logic [NREQ*16-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_q,
   output logic [15:0]          rsp_r,
   output logic                 rsp_dbz,
   output logic                 busy,
   output logic                 div_clear_n,
   output logic                 div_start,
   output logic [31:0]          div_a,
   output logic [15:0]          div_b,
   input  logic [31:0]          div_q,
   input  logic [15:0]          div_r
);

   localparam int CW = $clog2(DIV_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] idx;
   logic           grant_hit;
   logic [CW-1:0]  cnt;
   logic [31:0]    a_arr [NREQ];
   logic [15:0]    b_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[32*i +: 32];
      assign b_arr[i] = req_b[16*i +: 16];
   end

   // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NREQ.
   always_comb begin
      grant_hit = 1'b0;
      grant_idx = '0;
      idx       = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IDW'((32'(rr_ptr) + k) % NREQ);
         if (!grant_hit && req_valid[idx]) begin
            grant_hit = 1'b1;
            grant_idx = idx;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (clear) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and accept strobe.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      unique case (state)
         IDLE: begin
            if (grant_hit) begin
               req_ready[grant_idx] = 1'b1;
               state_nxt = (b_arr[grant_idx] == '0) ? DONE : START;
            end
         end
         START:   state_nxt = RUN;
         RUN:     if (cnt == CW'(1)) state_nxt = DONE;
         DONE:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State-decoded status and divider control outputs.
   always_comb begin
      rsp_valid   = (state == DONE);
      busy        = (state != IDLE);
      div_start   = (state == START);
      div_clear_n = ~clear;
   end

   // Operand latch, iteration counter, response capture and pointer update.
   always_ff @(posedge clk) begin
      if (clear) begin
         rr_ptr  <= '0;
         cnt     <= '0;
         div_a   <= '0;
         div_b   <= '0;
         rsp_id  <= '0;
         rsp_q   <= '0;
         rsp_r   <= '0;
         rsp_dbz <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_hit) begin
                  div_a  <= a_arr[grant_idx];
                  div_b  <= b_arr[grant_idx];
                  rsp_id <= grant_idx;
                  if (b_arr[grant_idx] == '0) begin
                     rsp_q   <= '1;
                     rsp_r   <= a_arr[grant_idx][15:0];
                     rsp_dbz <= 1'b1;
                  end
               end
            end
            START: cnt <= CW'(DIV_CYCLES);
            RUN: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  rsp_q   <= div_q;
                  rsp_r   <= div_r;
                  rsp_dbz <= 1'b0;
               end
            end
            DONE: begin
               if (rsp_ready)
                  rr_ptr <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: directed bench for div_share_ctrl with a behavioural
// divider whose result is only valid in the single cycle DIV_CYCLES after start.
module tb_div_share_ctrl;

   localparam int NREQ       = 4;
   localparam int IDW        = 2;
   localparam int DIV_CYCLES = 33;

   logic                 clk;
   logic                 clear;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*32-1:0]   req_a;
   logic [NREQ*16-1:0]   req_b;
   logic [NREQ-1:0]      req_ready;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [31:0]          rsp_q;
   logic [15:0]          rsp_r;
   logic                 rsp_dbz;
   logic                 busy;
   logic                 div_clear_n;
   logic                 div_start;
   logic [31:0]          div_a;
   logic [15:0]          div_b;
   logic [31:0]          div_q;
   logic [15:0]          div_r;

   int nchk  = 0;
   int npass = 0;
   int nfail = 0;

   div_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .DIV_CYCLES(DIV_CYCLES)) dut (
      .clk(clk), .clear(clear), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dbz(rsp_dbz), .busy(busy),
      .div_clear_n(div_clear_n), .div_start(div_start), .div_a(div_a), .div_b(div_b),
      .div_q(div_q), .div_r(div_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural divider: operands sampled on start, result valid only DIV_CYCLES cycles later.
   int          m_left = 0;
   logic [31:0] m_a = '0;
   logic [15:0] m_b = '0;
   always @(posedge clk) begin
      if (div_start) begin
         m_left <= DIV_CYCLES;
         m_a    <= div_a;
         m_b    <= div_b;
      end else if (m_left != 0) begin
         m_left <= m_left - 1;
      end
   end
   assign div_q = (m_left == 1 && m_b != 0) ? m_a / {16'b0, m_b} : 32'hDEAD_BEEF;
   assign div_r = (m_left == 1 && m_b != 0) ? 16'(m_a % {16'b0, m_b}) : 16'hBAD0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 200) begin
         step();
         n++;
      end
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [15:0] b);
      req_a[i*32 +: 32] = a;
      req_b[i*16 +: 16] = b;
   endtask

   int          n;
   int          seen;
   logic [1:0]  exp_id [5];
   logic [31:0] exp_q  [5];
   logic [15:0] exp_r  [5];
   logic [3:0]  one_hot;

   initial begin
      clear     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      step();

      // Reset state
      chk("rst_div_clear_n", div_clear_n, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_div_start", div_start, 0);
      chk("rst_div_a", div_a, 0);
      chk("rst_div_b", div_b, 0);
      chk("rst_rsp_q", rsp_q, 0);
      chk("rst_rsp_r", rsp_r, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_dbz", rsp_dbz, 0);
      clear = 1'b0;
      #1 chk("div_clear_n_rel", div_clear_n, 1);

      // Basic divide 100/7 from requester 0
      set_req(0, 100, 7);
      req_valid = 4'b0001;
      #1 chk("t1_req_ready", req_ready, 4'b0001);
      step();
      req_valid = '0;
      chk("t1_div_start", div_start, 1);
      chk("t1_div_a", div_a, 100);
      chk("t1_div_b", div_b, 7);
      chk("t1_busy", busy, 1);
      chk("t1_req_ready_off", req_ready, 0);
      step();
      chk("t1_div_start_once", div_start, 0);
      wait_rsp(n);
      chk("t1_latency", n, 33);
      chk("t1_rsp_id", rsp_id, 0);
      chk("t1_rsp_q", rsp_q, 14);
      chk("t1_rsp_r", rsp_r, 2);
      chk("t1_rsp_dbz", rsp_dbz, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("t1_rsp_drop", rsp_valid, 0);
      chk("t1_idle", busy, 0);

      // Backpressure: 1000/3 from requester 1 held 10 cycles, requester 2 waiting
      set_req(1, 1000, 3);
      req_valid = 4'b0010;
      #1 chk("t4_req_ready", req_ready, 4'b0010);
      step();
      set_req(2, 32'h0001_2345, 16'h0000);
      req_valid = 4'b0100;
      chk("t4_div_start", div_start, 1);
      wait_rsp(n);
      chk("t4_latency", n, 34);
      for (int unsigned k = 0; k < 10; k++) begin
         chk("t4_hold_valid", rsp_valid, 1);
         chk("t4_hold_q", rsp_q, 333);
         chk("t4_hold_r", rsp_r, 1);
         chk("t4_hold_id", rsp_id, 1);
         chk("t4_hold_no_ready", req_ready, 0);
         step();
      end
      rsp_ready = 1'b1;
      #1 chk("t4_valid_at_hs", rsp_valid, 1);
      step();
      rsp_ready = 1'b0;
      chk("t4_idle_busy", busy, 0);
      chk("t4_idle_valid", rsp_valid, 0);
      chk("t4_next_grant", req_ready, 4'b0100);

      // Divide-by-zero from requester 2
      step();
      req_valid = '0;
      chk("t2_rsp_valid", rsp_valid, 1);
      chk("t2_rsp_id", rsp_id, 2);
      chk("t2_rsp_q", rsp_q, 32'hFFFF_FFFF);
      chk("t2_rsp_r", rsp_r, 16'h2345);
      chk("t2_rsp_dbz", rsp_dbz, 1);
      chk("t2_no_start", div_start, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("t2_rsp_drop", rsp_valid, 0);
      chk("t2_no_start_after", div_start, 0);

      // Grant to requester 3, then 0 and 3 both valid: pointer wraps to 0
      set_req(3, 77, 0);
      req_valid = 4'b1000;
      #1 chk("t6_req_ready3", req_ready, 4'b1000);
      step();
      chk("t6_rsp_id3", rsp_id, 3);
      chk("t6_rsp_dbz3", rsp_dbz, 1);
      chk("t6_rsp_r3", rsp_r, 77);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      set_req(0, 32'hFFFF_FFFF, 16'hFFFF);
      req_valid = 4'b1001;
      #1 chk("t6_wrap_grant", req_ready, 4'b0001);
      step();
      req_valid = '0;
      wait_rsp(n);
      chk("t6_latency", n, 34);
      chk("t6_rsp_id0", rsp_id, 0);
      chk("t6_rsp_q", rsp_q, 32'h0001_0001);
      chk("t6_rsp_r", rsp_r, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      // Clear mid-RUN drops the in-flight request
      set_req(1, 555, 5);
      req_valid = 4'b0010;
      #1 chk("t5_req_ready", req_ready, 4'b0010);
      step();
      req_valid = '0;
      repeat (17) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_div_start", div_start, 0);
      chk("t5_div_a", div_a, 0);
      chk("t5_div_b", div_b, 0);
      chk("t5_rsp_q", rsp_q, 0);
      chk("t5_rsp_r", rsp_r, 0);
      chk("t5_rsp_id", rsp_id, 0);
      chk("t5_rsp_dbz", rsp_dbz, 0);
      chk("t5_req_ready", req_ready, 0);
      seen = 0;
      repeat (40) begin
         step();
         if (rsp_valid === 1'b1) seen++;
      end
      chk("t5_no_rsp", seen, 0);

      // All four requesters continuously valid: grants 0,1,2,3,0
      set_req(0, 32'h8000_0000, 3);
      set_req(1, 12345, 12346);
      set_req(2, 32'hFFFF_FFFF, 1);
      set_req(3, 1000000, 16'hFFFF);
      exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_q  = '{32'd715827882, 32'd0, 32'hFFFF_FFFF, 32'd15, 32'd715827882};
      exp_r  = '{16'd2, 16'd12345, 16'd0, 16'd16975, 16'd2};
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int unsigned k = 0; k < 5; k++) begin
         one_hot = 4'b0001 << exp_id[k];
         #1 chk("t3_grant", req_ready, one_hot);
         chk("t3_idle", busy, 0);
         step();
         wait_rsp(n);
         chk("t3_latency", n, 34);
         chk("t3_rsp_id", rsp_id, exp_id[k]);
         chk("t3_rsp_q", rsp_q, exp_q[k]);
         chk("t3_rsp_r", rsp_r, exp_r[k]);
         chk("t3_rsp_dbz", rsp_dbz, 0);
         step();
      end
      req_valid = '0;
      rsp_ready = 1'b0;

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Round-robin scheduler that shares one sequential 32/16 restoring divider among NREQ requesters.
- Accepts a dividend/divisor from the winning requester and pulses the divider start.
- Waits a fixed iteration count, then captures quotient/remainder and returns them on a single tagged response channel with backpressure.
- Handles divide-by-zero without occupying the divider.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ.
- DIV_CYCLES, 33, cycles from the divider start cycle (exclusive) to a valid q/r on div_q/div_r.

Ports:
- clk  in  1  clock, all logic on rising edge.
- clear  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*32  packed dividends; requester i uses bits [32i+31:32i].
- req_b  in  NREQ*16  packed divisors; requester i uses bits [16i+15:16i].
- req_ready  out  NREQ  one-hot accept strobe.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_q  out  32  quotient.
- rsp_r  out  16  remainder.
- rsp_dbz  out  1  divide-by-zero flag.
- busy  out  1  high in any state other than IDLE.
- div_clear_n  out  1  divider reset, active-low; equals ~clear.
- div_start  out  1  one-cycle divider start pulse.
- div_a  out  32  dividend to the divider.
- div_b  out  16  divisor to the divider.
- div_q  in  32  divider quotient.
- div_r  in  16  divider remainder.

Behaviour:
- Reset (clear=1 at posedge) sets:
  - state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_q=0, rsp_r=0, rsp_dbz=0, busy=0, div_start=0, div_a=0, div_b=0, iteration counter=0.
- Reset overrides every state, including mid-RUN and DONE. An in-flight request is dropped with no response.
- FSM states: IDLE, START, RUN, DONE.
- IDLE:
  - If any req_valid is high, grant g = first set bit searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle only. The handshake completes in that cycle.
  - Latch a_g, b_g and id=g.
  - If b_g==0: go to DONE with rsp_q=32'hFFFF_FFFF, rsp_r=a_g[15:0], rsp_dbz=1.
  - Otherwise go to START.
  - req_ready is 0 in every non-IDLE state.
- START:
  - div_start=1 for exactly this cycle; div_a/div_b hold the latched operands.
  - Load counter=DIV_CYCLES and go to RUN.
- RUN:
  - div_a/div_b remain stable; counter decrements each cycle.
  - In the cycle counter==1: capture div_q into rsp_q and div_r into rsp_r, set rsp_dbz=0, go to DONE.
- DONE:
  - rsp_valid=1; rsp_id/rsp_q/rsp_r/rsp_dbz stay stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready: rsp_valid drops next cycle, rr_ptr=(id+1) mod NREQ, go to IDLE.
- Latency, with acceptance in cycle T:
  - Normal request: rsp_valid first high in cycle T+2+DIV_CYCLES (T+35 at default).
  - Divide-by-zero: rsp_valid high in cycle T+1.
- Throughput: one outstanding request; the next grant is in the cycle after the response handshake at the earliest.
- req_valid deasserted before grant is not an error. Changes to req_a/req_b after acceptance have no effect.
- Grant arithmetic uses modulo NREQ; rr_ptr wraps from NREQ-1 to 0.
- rsp_id is zero-extended to IDW.

Test Plan:
1. Reset, then req_valid=4'b0001, a=100, b=7 accepted at T → at T+1 div_start=1, div_a=100, div_b=7; at T+35 rsp_valid=1, rsp_id=0, rsp_q=14, rsp_r=2, rsp_dbz=0.
2. Requester 2 sends a=32'h0001_2345, b=0 → accepted; next cycle rsp_valid=1, rsp_id=2, rsp_q=32'hFFFF_FFFF, rsp_r=16'h2345, rsp_dbz=1; div_start never pulses.
3. All four requesters valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0; each request accepted in the cycle after the previous response; results match the reference quotient/remainder.
4. Response ready for a=1000, b=3 with rsp_ready held low 10 cycles → rsp_valid, rsp_q=333, rsp_r=1 stable throughout; no req_ready asserts; IDLE resumes the cycle after rsp_ready rises.
5. Assert clear for 1 cycle mid-RUN (counter=17) → next cycle all outputs at reset values, busy=0; no response for the dropped request; a new request afterwards completes normally with rsp_id=0 priority.
6. Grant to requester 3, then requesters 0 and 3 both valid → next grant goes to 0, confirming wrap of rr_ptr.
